pg_bus_debounce: RTL and testbench

Downstream consumer of the 4-bit power-guard latch bus (`pg_bus` output) in the `osc_clk` domain. It synchronises the bus and the OSCTIMER `tmr_clk` output, debounces each bus bit on timer ticks, and presents a debounced copy of the bus. Every debounced change is reported as a one-entry, coalescing event over a valid/ready handshake.

---
 rtl/pg_pkg.sv | 12 +
 rtl/pg_bus_debounce_if.sv | 39 +++
 rtl/pg_bit_debounce.sv | 55 +++++
 rtl/pg_bus_debounce.sv | 118 +++++++++++
 tb/tb_pg_bus_debounce.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/pg_pkg.sv
// Shared definitions for the power-guard bus consumers.
//   PG_BUS_W            : width of the power-guard latch bus
//   PG_STABLE_TICKS_DEF : default number of timer ticks a bus bit must hold before acceptance
//   pg_bus_t            : one bus word
package pg_pkg;

  localparam int unsigned PG_BUS_W            = 4;
  localparam int unsigned PG_STABLE_TICKS_DEF = 3;

  typedef logic [PG_BUS_W-1:0] pg_bus_t;

endpackage

// File: rtl/pg_bus_debounce_if.sv
// Event handshake bundle between pg_bus_debounce and its consumer.
//   evt_valid : event pending                 (master -> slave)
//   evt_data  : debounced bus at last change  (master -> slave)
//   evt_mask  : bits changed since last accept (master -> slave)
//   evt_ovf   : sticky lost-edge flag         (master -> slave)
//   evt_ready : consumer accepts the event    (slave -> master)
//   ovf_clr   : clears evt_ovf                (slave -> master)
interface pg_bus_debounce_if
  import pg_pkg::*;
#(
  parameter int unsigned WIDTH = PG_BUS_W
) ();

  logic             evt_valid;
  logic [WIDTH-1:0] evt_data;
  logic [WIDTH-1:0] evt_mask;
  logic             evt_ovf;
  logic             evt_ready;
  logic             ovf_clr;

  modport master (
    output evt_valid,
    output evt_data,
    output evt_mask,
    output evt_ovf,
    input  evt_ready,
    input  ovf_clr
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    input  evt_mask,
    input  evt_ovf,
    output evt_ready,
    output ovf_clr
  );

endinterface

// File: rtl/pg_bit_debounce.sv
// Single-bit tick-based debouncer.
//   osc_clk : clock
//   rst_n   : asynchronous active-low reset
//   tick    : one-cycle strobe per timer period
//   b       : synchronised input bit
//   q       : debounced bit
//   q_next  : value q takes at the next edge (lets the parent see changes without extra latency)
module pg_bit_debounce
  import pg_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = PG_STABLE_TICKS_DEF
) (
  input  logic osc_clk,
  input  logic rst_n,
  input  logic tick,
  input  logic b,
  output logic q,
  output logic q_next
);

  localparam int unsigned CntW = $clog2(STABLE_TICKS + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            q_q, q_d;

  always_comb begin
    cnt_d = cnt_q;
    q_d   = q_q;
    if (tick) begin
      if (b == q_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntW'(STABLE_TICKS - 1)) begin
        q_d   = b;
        cnt_d = '0;
      end else if (cnt_q != {CntW{1'b1}}) begin
        // Saturate; unreachable with a consistent count but keeps the counter safe.
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      q_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q      = q_q;
  assign q_next = q_d;

endmodule

// File: rtl/pg_bus_debounce.sv
// Synchronises the power-guard bus and the timer clock, debounces each bus bit on timer
// ticks and reports every debounced change as a one-entry coalescing event.
//   osc_clk    : only clock
//   rst_n      : asynchronous active-low reset
//   tmr_clk_in : asynchronous timer clock, rising edge gives one tick
//   bus_in     : asynchronous power-guard bus
//   bus_q      : debounced bus
//   evt        : event handshake (valid/data/mask/ovf out, ready/ovf_clr in)
module pg_bus_debounce
  import pg_pkg::*;
#(
  parameter int unsigned WIDTH        = PG_BUS_W,
  parameter int unsigned STABLE_TICKS = PG_STABLE_TICKS_DEF
) (
  input  logic               osc_clk,
  input  logic               rst_n,
  input  logic               tmr_clk_in,
  input  logic [WIDTH-1:0]   bus_in,
  output logic [WIDTH-1:0]   bus_q,
  pg_bus_debounce_if.master  evt
);

  // Synchronisers and tick edge detect
  logic [WIDTH-1:0] bus_s1_q, bus_s2_q;
  logic             tmr_s1_q, tmr_s2_q, tmr_s3_q;
  logic             tick;

  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_s1_q <= '0;
      bus_s2_q <= '0;
      tmr_s1_q <= 1'b0;
      tmr_s2_q <= 1'b0;
      tmr_s3_q <= 1'b0;
    end else begin
      bus_s1_q <= bus_in;
      bus_s2_q <= bus_s1_q;
      tmr_s1_q <= tmr_clk_in;
      tmr_s2_q <= tmr_s1_q;
      tmr_s3_q <= tmr_s2_q;
    end
  end

  assign tick = tmr_s2_q & ~tmr_s3_q;

  // Per-bit debouncers
  logic [WIDTH-1:0] bus_q_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pg_bit_debounce #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .osc_clk(osc_clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .b      (bus_s2_q[i]),
      .q      (bus_q[i]),
      .q_next (bus_q_next[i])
    );
  end

  // Event slot
  logic [WIDTH-1:0] chg;
  logic             slot_free;
  logic             evt_valid_q, evt_valid_d;
  logic [WIDTH-1:0] evt_data_q, evt_data_d;
  logic [WIDTH-1:0] evt_mask_q, evt_mask_d;
  logic             evt_ovf_q, evt_ovf_d;

  assign chg       = bus_q_next ^ bus_q;
  assign slot_free = !evt_valid_q | evt.evt_ready;

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_data_d  = evt_data_q;
    evt_mask_d  = evt_mask_q;
    evt_ovf_d   = evt_ovf_q;
    if (evt.ovf_clr) begin
      evt_ovf_d = 1'b0;
    end
    if (chg != '0) begin
      evt_data_d = bus_q_next;
      if (slot_free) begin
        evt_valid_d = 1'b1;
        evt_mask_d  = chg;
      end else begin
        evt_mask_d = evt_mask_q | chg;
        // A bit that toggles again before being read loses its intermediate edge.
        if ((evt_mask_q & chg) != '0) begin
          evt_ovf_d = 1'b1;
        end
      end
    end else if (evt_valid_q && evt.evt_ready) begin
      evt_valid_d = 1'b0;
      evt_mask_d  = '0;
    end
  end

  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_data_q  <= '0;
      evt_mask_q  <= '0;
      evt_ovf_q   <= 1'b0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_data_q  <= evt_data_d;
      evt_mask_q  <= evt_mask_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_data  = evt_data_q;
  assign evt.evt_mask  = evt_mask_q;
  assign evt.evt_ovf   = evt_ovf_q;

endmodule

// File: tb/tb_pg_bus_debounce.sv
module tb_pg_bus_debounce;
  import pg_pkg::*;

  logic    osc_clk = 1'b0;
  logic    rst_n;
  logic    tmr_clk_in;
  pg_bus_t bus_in;
  pg_bus_t bus_q;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  pg_bus_debounce_if #(.WIDTH(PG_BUS_W)) evt ();

  pg_bus_debounce #(
    .WIDTH       (PG_BUS_W),
    .STABLE_TICKS(3)
  ) u_dut (
    .osc_clk   (osc_clk),
    .rst_n     (rst_n),
    .tmr_clk_in(tmr_clk_in),
    .bus_in    (bus_in),
    .bus_q     (bus_q),
    .evt       (evt)
  );

  always #5 osc_clk = ~osc_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One timer period. Inputs change on falling edges; the debounce update lands on the
  // third rising edge after tmr_clk_in rises. ready_at_upd / clr_at_upd drive evt_ready /
  // ovf_clr for exactly the cycle ending on that edge.
  task automatic do_tick(input logic ready_at_upd = 1'b0, input logic clr_at_upd = 1'b0);
    tmr_clk_in = 1'b1;
    @(negedge osc_clk);
    @(negedge osc_clk);
    evt.evt_ready = ready_at_upd;
    evt.ovf_clr   = clr_at_upd;
    @(negedge osc_clk);
    evt.evt_ready = 1'b0;
    evt.ovf_clr   = 1'b0;
    @(negedge osc_clk);
    tmr_clk_in = 1'b0;
    repeat (4) @(negedge osc_clk);
  endtask

  task automatic pulse_ready();
    evt.evt_ready = 1'b1;
    @(negedge osc_clk);
    evt.evt_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge osc_clk);
    rst_n = 1'b1;
    @(negedge osc_clk);
  endtask

  task automatic check_evt(input string tag, input logic v, input pg_bus_t m, input pg_bus_t d);
    check({tag, ".valid"}, 32'(evt.evt_valid), 32'(v));
    check({tag, ".mask"},  32'(evt.evt_mask),  32'(m));
    check({tag, ".data"},  32'(evt.evt_data),  32'(d));
  endtask

  initial begin
    rst_n         = 1'b0;
    tmr_clk_in    = 1'b0;
    bus_in        = 4'h0;
    evt.evt_ready = 1'b0;
    evt.ovf_clr   = 1'b0;
    @(negedge osc_clk);
    check("rst.bus_q", 32'(bus_q), 32'h0);
    check_evt("rst", 1'b0, 4'h0, 4'h0);
    check("rst.ovf", 32'(evt.evt_ovf), 32'h0);
    rst_n = 1'b1;
    @(negedge osc_clk);

    // Reset default: idle bus for 10 ticks
    for (int i = 0; i < 10; i++) begin
      do_tick();
      check("idle.bus_q", 32'(bus_q), 32'h0);
      check("idle.valid", 32'(evt.evt_valid), 32'h0);
      check("idle.ovf", 32'(evt.evt_ovf), 32'h0);
    end

    // Debounced set 0 -> 5
    bus_in = 4'h5;
    do_tick();
    check("set.t1.bus_q", 32'(bus_q), 32'h0);
    do_tick();
    check("set.t2.bus_q", 32'(bus_q), 32'h0);
    check("set.t2.valid", 32'(evt.evt_valid), 32'h0);
    do_tick();
    check("set.t3.bus_q", 32'(bus_q), 32'h5);
    check_evt("set.t3", 1'b1, 4'h5, 4'h5);
    pulse_ready();
    check_evt("set.acc", 1'b0, 4'h0, 4'h5);

    // Glitch rejection on bit 1
    bus_in = 4'h7;
    do_tick();
    do_tick();
    bus_in = 4'h5;
    do_tick();
    check("glitch.t3.bus_q", 32'(bus_q), 32'h5);
    bus_in = 4'h7;
    do_tick();
    do_tick();
    check("glitch.t5.bus_q", 32'(bus_q), 32'h5);
    check("glitch.t5.valid", 32'(evt.evt_valid), 32'h0);
    do_tick();
    check("glitch.t6.bus_q", 32'(bus_q), 32'h7);
    check_evt("glitch.t6", 1'b1, 4'h2, 4'h7);

    // Coalescing and overflow
    do_reset();
    check_evt("co.rst", 1'b0, 4'h0, 4'h0);
    bus_in = 4'h1;
    repeat (3) do_tick();
    check_evt("co.b0", 1'b1, 4'h1, 4'h1);
    bus_in = 4'h5;
    repeat (3) do_tick();
    check_evt("co.b2", 1'b1, 4'h5, 4'h5);
    check("co.b2.ovf", 32'(evt.evt_ovf), 32'h0);
    bus_in = 4'h4;
    repeat (3) do_tick();
    check_evt("co.b0off", 1'b1, 4'h5, 4'h4);
    check("co.b0off.ovf", 32'(evt.evt_ovf), 32'h1);
    bus_in = 4'h5;
    do_tick();
    do_tick();
    do_tick(1'b0, 1'b1);
    check("co.setwins.ovf", 32'(evt.evt_ovf), 32'h1);
    check_evt("co.setwins", 1'b1, 4'h5, 4'h5);
    evt.ovf_clr = 1'b1;
    @(negedge osc_clk);
    evt.ovf_clr = 1'b0;
    check("co.clr.ovf", 32'(evt.evt_ovf), 32'h0);

    // Accept/update collision on bit 3
    bus_in = 4'hD;
    do_tick();
    do_tick();
    do_tick(1'b1, 1'b0);
    check_evt("coll", 1'b1, 4'h8, 4'hD);
    check("coll.ovf", 32'(evt.evt_ovf), 32'h0);
    check("coll.bus_q", 32'(bus_q), 32'hD);
    pulse_ready();
    check_evt("coll.acc", 1'b0, 4'h0, 4'hD);

    // Reset mid-count
    do_reset();
    bus_in = 4'hF;
    do_tick();
    do_tick();
    rst_n = 1'b0;
    #1;
    check("mid.inrst.bus_q", 32'(bus_q), 32'h0);
    check_evt("mid.inrst", 1'b0, 4'h0, 4'h0);
    @(negedge osc_clk);
    rst_n = 1'b1;
    @(negedge osc_clk);
    check("mid.rel.bus_q", 32'(bus_q), 32'h0);
    do_tick();
    do_tick();
    check("mid.t2.bus_q", 32'(bus_q), 32'h0);
    check("mid.t2.valid", 32'(evt.evt_valid), 32'h0);
    do_tick();
    check("mid.t3.bus_q", 32'(bus_q), 32'hF);
    check_evt("mid.t3", 1'b1, 4'hF, 4'hF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
